// File: rtl/feature_window_fetch.sv
// Feature-map window fetch: stores one feature map and streams KxKxdepth convolution windows with zero padding.
// Define FEATURE_FETCH_KERNEL5_EN to enable 5x5 windows (iKernelSize=2); otherwise that code is rejected.
module feature_window_fetch #(
  parameter int P_FEATURE_MEMORY_SIZE = 65536,
  parameter int P_BINDWIDTH           = 64,
  parameter int P_ADDR_W              = $clog2(P_FEATURE_MEMORY_SIZE / P_BINDWIDTH),
  parameter int P_HW_W                = 6,
  parameter int P_DEPTH_W             = 4
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   nWe,
  input  logic [P_ADDR_W-1:0]    iWriteAddr,
  input  logic [P_BINDWIDTH-1:0] iWriteData,
  input  logic                   iStart,
  input  logic [P_HW_W-1:0]      iRow,
  input  logic [P_HW_W-1:0]      iCol,
  input  logic [P_HW_W-1:0]      inHW,
  input  logic [P_DEPTH_W-1:0]   iDepth,
  input  logic [1:0]             iKernelSize,
  input  logic                   iReady,
  output logic                   oValid,
  output logic [P_BINDWIDTH-1:0] oFeatureData,
  output logic                   oZeroPad,
  output logic                   oLast,
  output logic                   oBusy,
  output logic                   oErr
);

  localparam int WORDS = P_FEATURE_MEMORY_SIZE / P_BINDWIDTH;
`ifdef FEATURE_FETCH_KERNEL5_EN
  localparam int CW = 3;
`else
  localparam int CW = 2;
`endif
  localparam int YW    = P_HW_W + 2;
  localparam int IW_A  = P_ADDR_W + 2;
  localparam int IW_B  = P_HW_W + 3;
  localparam int IW_C  = P_DEPTH_W + 1;
  localparam int IW_AB = (IW_A > IW_B) ? IW_A : IW_B;
  localparam int IW    = (IW_AB > IW_C) ? IW_AB : IW_C;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t state_q, state_d;

  logic [P_BINDWIDTH-1:0] mem [WORDS];
  logic [P_BINDWIDTH-1:0] ram_q;

  logic [P_HW_W-1:0]    row_q, col_q, hw_q;
  logic [P_DEPTH_W-1:0] depth_q, d_q;
  logic signed [CW-1:0] r_q, ty_q, tx_q, r_in;

  logic ks_ok, legal, accept_req, adv, busy;
  logic valid_q, zero_q, pad_q, last_q, err_q;

  logic signed [YW-1:0] y_tap, x_tap, hw_s;
  logic                 tap_pad, d_last, tap_last;
  logic signed [IW-1:0] y_e, x_e, hw_e, dep_e, d_e, addr_full;
  logic [P_ADDR_W-1:0]  tap_addr;
  logic [IW-P_ADDR_W-1:0] unused_addr_hi;

  always_comb begin
    ks_ok = 1'b0;
    r_in  = '0;
    case (iKernelSize)
      2'd1: ks_ok = 1'b1;
      2'd3: begin
        ks_ok = 1'b1;
        r_in  = CW'(1);
      end
`ifdef FEATURE_FETCH_KERNEL5_EN
      2'd2: begin
        ks_ok = 1'b1;
        r_in  = CW'(2);
      end
`endif
      default: ks_ok = 1'b0;
    endcase
    legal = ks_ok && (iDepth != '0) && (inHW != '0) && (iRow < inHW) && (iCol < inHW);
    accept_req = (state_q == IDLE) && iStart && legal;
  end

  // Signed tap coordinates give the padding test; the address wraps modulo the word count.
  always_comb begin
    y_tap   = $signed({2'b00, row_q}) + $signed({{(YW-CW){ty_q[CW-1]}}, ty_q});
    x_tap   = $signed({2'b00, col_q}) + $signed({{(YW-CW){tx_q[CW-1]}}, tx_q});
    hw_s    = $signed({2'b00, hw_q});
    tap_pad = y_tap[YW-1] || x_tap[YW-1] || (y_tap >= hw_s) || (x_tap >= hw_s);

    y_e   = $signed({{(IW-YW){y_tap[YW-1]}}, y_tap});
    x_e   = $signed({{(IW-YW){x_tap[YW-1]}}, x_tap});
    hw_e  = $signed({{(IW-P_HW_W){1'b0}}, hw_q});
    dep_e = $signed({{(IW-P_DEPTH_W){1'b0}}, depth_q});
    d_e   = $signed({{(IW-P_DEPTH_W){1'b0}}, d_q});
    addr_full = (y_e * hw_e + x_e) * dep_e + d_e;
    {unused_addr_hi, tap_addr} = addr_full;

    d_last   = (d_q == depth_q - P_DEPTH_W'(1));
    tap_last = d_last && (tx_q == r_q) && (ty_q == r_q);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_req) state_d = FETCH;
      FETCH:   if (adv && tap_last) state_d = DRAIN;
      DRAIN:   if (valid_q && iReady && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    adv  = (state_q == FETCH) && (!valid_q || iReady);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_q   <= '0;
      col_q   <= '0;
      hw_q    <= '0;
      depth_q <= '0;
      r_q     <= '0;
      ty_q    <= '0;
      tx_q    <= '0;
      d_q     <= '0;
    end else if (accept_req) begin
      row_q   <= iRow;
      col_q   <= iCol;
      hw_q    <= inHW;
      depth_q <= iDepth;
      r_q     <= r_in;
      ty_q    <= -r_in;
      tx_q    <= -r_in;
      d_q     <= '0;
    end else if (adv) begin
      // Depth is the fastest counter, then column, then row.
      if (d_last) begin
        d_q <= '0;
        if (tx_q == r_q) begin
          tx_q <= -r_q;
          ty_q <= ty_q + CW'(1);
        end else begin
          tx_q <= tx_q + CW'(1);
        end
      end else begin
        d_q <= d_q + P_DEPTH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
      pad_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && iStart && !legal;
      if (adv) begin
        valid_q <= 1'b1;
        zero_q  <= tap_pad;
        pad_q   <= tap_pad;
        last_q  <= tap_last;
      end else if (valid_q && iReady) begin
        valid_q <= 1'b0;
        zero_q  <= 1'b1;
        pad_q   <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nWe) mem[iWriteAddr] <= iWriteData;
  end

  // Padding taps skip the read; zero_q masks the stale RAM output instead.
  always_ff @(posedge clk) begin
    if (adv && !tap_pad) ram_q <= mem[tap_addr];
  end

  assign oValid       = valid_q;
  assign oFeatureData = zero_q ? '0 : ram_q;
  assign oZeroPad     = pad_q;
  assign oLast        = last_q;
  assign oBusy        = busy;
  assign oErr         = err_q;

endmodule

// File: tb/tb_feature_window_fetch.sv
// Scoreboard bench for feature_window_fetch: expected tap words are queued per request and compared as the DUT hands them over.
module tb_feature_window_fetch;

  localparam int BW = 64;
  localparam int AW = 10;
  localparam int HW = 6;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          nRst;
  logic          nWe;
  logic [AW-1:0] iWriteAddr;
  logic [BW-1:0] iWriteData;
  logic          iStart;
  logic [HW-1:0] iRow, iCol, inHW;
  logic [DW-1:0] iDepth;
  logic [1:0]    iKernelSize;
  logic          iReady;
  logic          oValid;
  logic [BW-1:0] oFeatureData;
  logic          oZeroPad, oLast, oBusy, oErr;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          pad;
    logic          last;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  feature_window_fetch dut (
    .clk(clk), .nRst(nRst), .nWe(nWe), .iWriteAddr(iWriteAddr), .iWriteData(iWriteData),
    .iStart(iStart), .iRow(iRow), .iCol(iCol), .inHW(inHW), .iDepth(iDepth),
    .iKernelSize(iKernelSize), .iReady(iReady), .oValid(oValid), .oFeatureData(oFeatureData),
    .oZeroPad(oZeroPad), .oLast(oLast), .oBusy(oBusy), .oErr(oErr)
  );

  task automatic push_exp(input int data, input bit pad, input bit last);
    word_t w;
    w.data = BW'(data);
    w.pad  = pad;
    w.last = last;
    exp_q.push_back(w);
  endtask

  task automatic start_window(input int row, input int col, input int hw, input int depth, input int ks);
    iRow        = HW'(row);
    iCol        = HW'(col);
    inHW        = HW'(hw);
    iDepth      = DW'(depth);
    iKernelSize = 2'(ks);
    iStart      = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  // Collects handed-over words into obs_q; cycles counts negedges after the iStart edge until oBusy drops.
  task automatic run_handshake(input bit toggle, input int budget, output int cycles,
                               output int unstable, output bit timeout);
    word_t held, w;
    bit prev_stall;
    cycles = 0; unstable = 0; timeout = 1'b0; prev_stall = 1'b0; held = '0;
    forever begin
      if (prev_stall && (oValid !== 1'b1 || {oFeatureData, oZeroPad, oLast} !== held)) unstable++;
      if (!oBusy && !oValid) break;
      if (cycles >= budget) begin
        timeout = 1'b1;
        break;
      end
      if (toggle) iReady = ~iReady;
      if (oValid && iReady) begin
        w = {oFeatureData, oZeroPad, oLast};
        obs_q.push_back(w);
      end
      prev_stall = oValid && !iReady;
      held = {oFeatureData, oZeroPad, oLast};
      @(negedge clk);
      cycles++;
    end
    iReady = 1'b1;
  endtask

  task automatic test_reset();
    nRst = 1'b0; nWe = 1'b1; iWriteAddr = '0; iWriteData = '0; iStart = 1'b0;
    iRow = '0; iCol = '0; inHW = '0; iDepth = '0; iKernelSize = '0; iReady = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({oValid, oZeroPad, oLast, oBusy, oErr} !== 5'b0)
      $display("FAIL reset flags: got %b, want 00000", {oValid, oZeroPad, oLast, oBusy, oErr});
    else n_pass++;
    n_checks++;
    if (oFeatureData !== '0) $display("FAIL reset data: got %0h, want 0", oFeatureData);
    else n_pass++;
    nRst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({oBusy, oValid} !== 2'b00) $display("FAIL after reset busy/valid: got %b, want 00", {oBusy, oValid});
    else n_pass++;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) begin
      iWriteAddr = AW'(i);
      iWriteData = BW'(i);
      nWe = 1'b0;
      @(negedge clk);
    end
    nWe = 1'b1;
  endtask

  task automatic test_1x1();
    int cycles, unstable, k;
    bit timeout;
    word_t e, o;
    push_exp(56, 0, 0);
    push_exp(57, 0, 1);
    start_window(3, 4, 8, 2, 1);
    run_handshake(1'b0, 20, cycles, unstable, timeout);
    n_checks++;
    if (timeout || cycles !== 3) $display("FAIL 1x1 busy span: got %0d cycles timeout=%0b, want 3", cycles, timeout);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL 1x1 count: got %0d, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL 1x1 tap %0d: got data=%0d pad=%0b last=%0b, want data=%0d pad=%0b last=%0b",
                            k, o.data, o.pad, o.last, e.data, e.pad, e.last);
      else n_pass++;
      k++;
    end
    obs_q.delete();
  endtask

  task automatic test_pad_top_left();
    int cycles, unstable, k;
    bit timeout;
    word_t e, o;
    push_exp(0, 1, 0); push_exp(0, 1, 0); push_exp(0, 1, 0);
    push_exp(0, 1, 0); push_exp(0, 0, 0); push_exp(1, 0, 0);
    push_exp(0, 1, 0); push_exp(4, 0, 0); push_exp(5, 0, 1);
    start_window(0, 0, 4, 1, 3);
    run_handshake(1'b0, 40, cycles, unstable, timeout);
    n_checks++;
    if (timeout || cycles !== 10) $display("FAIL top-left busy span: got %0d cycles timeout=%0b, want 10", cycles, timeout);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL top-left count: got %0d, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL top-left tap %0d: got data=%0d pad=%0b last=%0b, want data=%0d pad=%0b last=%0b",
                            k, o.data, o.pad, o.last, e.data, e.pad, e.last);
      else n_pass++;
      k++;
    end
    obs_q.delete();
  endtask

  task automatic test_pad_bottom_right_stall();
    int cycles, unstable, k;
    bit timeout;
    word_t e, o;
    push_exp(10, 0, 0); push_exp(11, 0, 0); push_exp(0, 1, 0);
    push_exp(14, 0, 0); push_exp(15, 0, 0); push_exp(0, 1, 0);
    push_exp(0, 1, 0);  push_exp(0, 1, 0);  push_exp(0, 1, 1);
    start_window(3, 3, 4, 1, 3);
    run_handshake(1'b1, 80, cycles, unstable, timeout);
    n_checks++;
    if (timeout) $display("FAIL stall window timeout: got %0d cycles, want below 80", cycles);
    else n_pass++;
    n_checks++;
    if (unstable !== 0) $display("FAIL stall hold: got %0d changes while stalled, want 0", unstable);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL stall count: got %0d, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL stall tap %0d: got data=%0d pad=%0b last=%0b, want data=%0d pad=%0b last=%0b",
                            k, o.data, o.pad, o.last, e.data, e.pad, e.last);
      else n_pass++;
      k++;
    end
    obs_q.delete();
  endtask

  task automatic test_illegal();
    // {kernel, depth, hw, row, col}
    int reqs [4][5] = '{'{0, 1, 8, 0, 0}, '{3, 0, 8, 1, 1}, '{3, 1, 4, 4, 0}, '{1, 1, 4, 0, 4}};
    for (int i = 0; i < 4; i++) begin
      start_window(reqs[i][3], reqs[i][4], reqs[i][2], reqs[i][1], reqs[i][0]);
      n_checks++;
      if ({oErr, oBusy, oValid} !== 3'b100)
        $display("FAIL illegal %0d pulse: got err/busy/valid=%b, want 100", i, {oErr, oBusy, oValid});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({oErr, oBusy, oValid} !== 3'b000)
        $display("FAIL illegal %0d after: got err/busy/valid=%b, want 000", i, {oErr, oBusy, oValid});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int cycles, unstable, acc, k;
    bit timeout;
    word_t e, o;
    acc = 0;
    start_window(1, 1, 4, 1, 3);
    for (int c = 0; c < 30 && acc < 4; c++) begin
      @(negedge clk);
      if (oValid && iReady) acc++;
    end
    n_checks++;
    if (acc !== 4) $display("FAIL reset-mid reach tap 4: got %0d accepted, want 4", acc);
    else n_pass++;
    nRst = 1'b0;
    #1;
    n_checks++;
    if ({oValid, oBusy, oLast, oZeroPad} !== 4'b0 || oFeatureData !== '0)
      $display("FAIL reset-mid outputs: got valid/busy/last/pad=%b data=%0d, want 0000 0",
               {oValid, oBusy, oLast, oZeroPad}, oFeatureData);
    else n_pass++;
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    push_exp(0, 0, 1);
    start_window(0, 0, 4, 1, 1);
    run_handshake(1'b0, 20, cycles, unstable, timeout);
    n_checks++;
    if (timeout || cycles !== 2) $display("FAIL reset-mid restart span: got %0d cycles timeout=%0b, want 2", cycles, timeout);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL reset-mid count: got %0d, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL reset-mid tap %0d: got data=%0d pad=%0b last=%0b, want data=%0d pad=%0b last=%0b",
                            k, o.data, o.pad, o.last, e.data, e.pad, e.last);
      else n_pass++;
      k++;
    end
    obs_q.delete();
  endtask

  task automatic test_kernel5();
`ifdef FEATURE_FETCH_KERNEL5_EN
    int cycles, unstable, k;
    bit timeout;
    word_t e, o;
    for (int i = 0; i < 25; i++) push_exp(i, 0, i == 24);
    start_window(2, 2, 5, 1, 2);
    run_handshake(1'b0, 100, cycles, unstable, timeout);
    n_checks++;
    if (timeout || cycles !== 26) $display("FAIL 5x5 busy span: got %0d cycles timeout=%0b, want 26", cycles, timeout);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL 5x5 count: got %0d, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL 5x5 tap %0d: got data=%0d pad=%0b last=%0b, want data=%0d pad=%0b last=%0b",
                            k, o.data, o.pad, o.last, e.data, e.pad, e.last);
      else n_pass++;
      k++;
    end
    obs_q.delete();
`else
    start_window(2, 2, 5, 1, 2);
    n_checks++;
    if ({oErr, oBusy, oValid} !== 3'b100)
      $display("FAIL 5x5 rejected pulse: got err/busy/valid=%b, want 100", {oErr, oBusy, oValid});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({oErr, oBusy, oValid} !== 3'b000)
      $display("FAIL 5x5 rejected after: got err/busy/valid=%b, want 000", {oErr, oBusy, oValid});
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    int cycles_a, cycles_b, unstable, k;
    bit timeout_a, timeout_b;
    word_t e, o;
    push_exp(56, 0, 0);
    push_exp(57, 0, 1);
    start_window(3, 4, 8, 2, 1);
    run_handshake(1'b0, 20, cycles_a, unstable, timeout_a);
    push_exp(1, 0, 1);
    start_window(0, 1, 4, 1, 1);
    run_handshake(1'b0, 20, cycles_b, unstable, timeout_b);
    n_checks++;
    if (timeout_a || timeout_b || cycles_a !== 3 || cycles_b !== 2)
      $display("FAIL back-to-back spans: got %0d,%0d cycles, want 3,2", cycles_a, cycles_b);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL back-to-back count: got %0d, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL back-to-back tap %0d: got data=%0d pad=%0b last=%0b, want data=%0d pad=%0b last=%0b",
                            k, o.data, o.pad, o.last, e.data, e.pad, e.last);
      else n_pass++;
      k++;
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    fill_mem();
    test_1x1();
    test_pad_top_left();
    test_pad_bottom_right_stall();
    test_illegal();
    test_reset_mid();
    test_kernel5();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000ns, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
